// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: loads a pattern into a scan chain, captures, unloads and compares the response.
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 4
) (
    input  logic                 clk,
    input  logic                 r,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pat_in,
    input  logic [CHAIN_LEN-1:0] exp_in,
    input  logic                 so,
    output logic                 si,
    output logic                 se,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CHAIN_LEN-1:0] resp_out
);
    localparam int CW = $clog2(CHAIN_LEN);
    localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);
    typedef enum logic [2:0] {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE} state_t;
    state_t               state;
    logic [CW-1:0]        cnt;
    logic [CHAIN_LEN-1:0] pat, exp_v, resp;
    // pat shifts left so its MSB always holds the next scan-in bit; resp fills from the LSB
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state    <= IDLE;
            cnt      <= '0;
            pat      <= '0;
            exp_v    <= '0;
            resp     <= '0;
            si       <= 1'b0;
            se       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            resp_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    pat   <= pat_in;
                    exp_v <= exp_in;
                    cnt   <= '0;
                    se    <= 1'b1;
                    si    <= pat_in[CHAIN_LEN-1];
                    busy  <= 1'b1;
                    state <= SHIFT_IN;
                end
                SHIFT_IN: if (cnt == LAST) begin
                    cnt   <= '0;
                    se    <= 1'b0;
                    si    <= 1'b0;
                    state <= CAPTURE;
                end else begin
                    cnt <= cnt + 1'b1;
                    si  <= pat[CHAIN_LEN-2];
                    pat <= pat << 1;
                end
                CAPTURE: begin
                    cnt   <= '0;
                    se    <= 1'b1;
                    state <= SHIFT_OUT;
                end
                SHIFT_OUT: begin
                    resp <= {resp[CHAIN_LEN-2:0], so};
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        se    <= 1'b0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done     <= 1'b1;
                    pass     <= resp == exp_v;
                    resp_out <= resp;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: drives scan_chain_ctrl against a behavioural 4-bit scan chain and checks results.
module tb_scan_chain_ctrl;
    localparam int N = 4;
    logic clk = 1'b0, r = 1'b1, start = 1'b0;
    logic [N-1:0] pat_in = '0, exp_in = '0, pi_v = '0, chain = '0;
    logic so, si, se, busy, done, pass;
    logic [N-1:0] resp_out;
    bit hold = 1'b0;
    int n_chk = 0, n_fail = 0;

    typedef struct {
        logic [N-1:0] pat, pi, expv;
        bit           hold, pulses;
        logic [N-1:0] resp;
        bit           pass_e;
    } vec_t;
    vec_t tbl[5];

    always #5 clk = ~clk;

    // chain[0] sits next to si, chain[N-1] drives so; hold suppresses parallel capture
    assign so = chain[N-1];
    always @(posedge clk) begin
        if (se) chain <= {chain[N-2:0], si};
        else if (!hold) chain <= pi_v;
    end

    scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
        .clk(clk), .r(r), .start(start), .pat_in(pat_in), .exp_in(exp_in), .so(so),
        .si(si), .se(se), .busy(busy), .done(done), .pass(pass), .resp_out(resp_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // one full test from an idle controller; cycle k is the k-th cycle after the accepting edge
    task automatic run_test(input string tag, input logic [N-1:0] p, pv, e,
                            input bit h, pulses, input logic [N-1:0] resp_e, input bit pass_e);
        logic [N-1:0] sh = p;
        logic [3:0] want;
        @(negedge clk);
        pat_in = p; exp_in = e; pi_v = pv; hold = h; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        pat_in = 4'($urandom); exp_in = 4'($urandom);
        for (int k = 1; k <= 2 * N + 4; k++) begin
            @(negedge clk);
            if (k <= N) begin
                want = {1'b1, sh[N-1], 2'b10};
                sh = sh << 1;
            end else if (k == N + 1) want = 4'b0010;
            else if (k <= 2 * N + 1) want = 4'b1010;
            else if (k == 2 * N + 2) want = 4'b0010;
            else if (k == 2 * N + 3) want = 4'b0001;
            else want = 4'b0000;
            chk($sformatf("%s.c%0d se_si_busy_done", tag, k), 32'({se, si, busy, done}), 32'(want));
            if (k == 2 * N + 3) begin
                chk({tag, ".resp_out"}, 32'(resp_out), 32'(resp_e));
                chk({tag, ".pass"}, 32'(pass), 32'(pass_e));
            end
            start = pulses && (k == 3 || k == 7);
        end
        start = 1'b0;
        hold = 1'b0;
    endtask

    initial begin
        tbl[0] = '{4'b1011, 4'b0110, 4'b0110, 1'b0, 1'b0, 4'b0110, 1'b1};
        tbl[1] = '{4'b1011, 4'b0110, 4'b0111, 1'b0, 1'b0, 4'b0110, 1'b0};
        tbl[2] = '{4'b1001, 4'b0110, 4'b1001, 1'b1, 1'b0, 4'b1001, 1'b1};
        tbl[3] = '{4'b1100, 4'b1010, 4'b1010, 1'b0, 1'b1, 4'b1010, 1'b1};
        tbl[4] = '{4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b1111, 1'b0};

        #12;
        chk("reset outputs", 32'({se, si, busy, done, pass, resp_out}), 32'(0));
        @(negedge clk);
        r = 1'b0;

        for (int i = 0; i < 5; i++)
            run_test($sformatf("vec%0d", i), tbl[i].pat, tbl[i].pi, tbl[i].expv,
                     tbl[i].hold, tbl[i].pulses, tbl[i].resp, tbl[i].pass_e);

        // random patterns against the spec-level model: the chain returns pi, or the pattern if capture is held off
        for (int i = 0; i < 20; i++) begin
            logic [N-1:0] p, pv, e, re;
            bit h;
            p = 4'($urandom); pv = 4'($urandom); h = 1'($urandom);
            re = h ? p : pv;
            e = ($urandom_range(0, 1) == 1) ? re : 4'($urandom);
            run_test($sformatf("rnd%0d", i), p, pv, e, h, 1'b0, re, e == re);
        end

        // reset in the middle of SHIFT_OUT aborts with no done pulse
        begin
            int seen = 0;
            @(negedge clk);
            pat_in = 4'b1110; exp_in = 4'b0101; pi_v = 4'b0101; start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            repeat (7) @(negedge clk);
            #2 r = 1'b1;
            #1 chk("async reset", 32'({se, si, busy, done}), 32'(0));
            @(negedge clk);
            r = 1'b0;
            for (int k = 0; k < 14; k++) begin
                @(negedge clk);
                if (done) seen++;
            end
            chk("no done after abort", 32'(seen), 32'(0));
            run_test("post_reset", 4'b0011, 4'b1001, 4'b1001, 1'b0, 1'b0, 4'b1001, 1'b1);
        end

        // start held high: tests run back to back with a period of 2N+3 cycles
        @(negedge clk);
        pat_in = 4'b0101; exp_in = 4'b0110; pi_v = 4'b0110; start = 1'b1;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            chk($sformatf("b2b.c%0d done", c), 32'(done), 32'(c % (2 * N + 3) == 0));
            if (done) chk($sformatf("b2b.c%0d pass", c), 32'({pass, resp_out}), 32'({1'b1, 4'b0110}));
            if (c == 30) start = 1'b0;
        end
        begin
            int t = 0;
            while (busy && t < 20) begin
                @(negedge clk);
                t++;
            end
            chk("b2b idle", 32'(busy), 32'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
